// File: rtl/bus_cycle_controller_pkg.sv
// -----------------------------------------------------------------------------
// bus_cycle_controller_pkg
//   Shared definitions for the k30p CPU bus-cycle terminator: active-low signal
//   levels, DSACK port-size codes, the CPU-space function code and the
//   controller FSM / termination-mode encodings.
//   No ports (package).
// -----------------------------------------------------------------------------
package bus_cycle_controller_pkg;

    // Levels for the active-low bus strobes (AS, DSACK, BERR, selects).
    localparam logic ACTIVE   = 1'b0;
    localparam logic INACTIVE = 1'b1;

    // DSACK[1:0] active-low port-size codes.
    localparam logic [1:0] DSACK_32   = 2'b00;
    localparam logic [1:0] DSACK_16   = 2'b01;
    localparam logic [1:0] DSACK_8    = 2'b10;
    localparam logic [1:0] DSACK_NONE = 2'b11;

    // Function code of a CPU-space (interrupt acknowledge) cycle.
    localparam logic [2:0] FC_CPU_SPACE = 3'b111;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_WAIT  = 3'd1,
        ST_ACK   = 3'd2,
        ST_BERR  = 3'd3,
        ST_DRAIN = 3'd4
    } state_e;

    // Who terminates the cycle currently in WAIT.
    typedef enum logic [1:0] {
        MODE_LOCAL = 2'd0,   // wait-state counter, programmed port size
        MODE_EXT   = 2'd1,   // ext_dsack / ext_berr
        MODE_NONE  = 2'd2    // CPU-space cycle, only the watchdog can end it here
    } mode_e;

endpackage

// File: rtl/bus_cycle_controller_sync_chain.sv
// -----------------------------------------------------------------------------
// sync_chain
//   WIDTH-bit flop synchroniser, STAGES flops deep (STAGES >= 1). Every stage
//   resets to all-ones, the idle level of the active-low strobes it carries.
//   Ports:
//     clock  in   1      system clock
//     reset  in   1      synchronous, active-high
//     d_i    in   WIDTH  asynchronous inputs
//     q_o    out  WIDTH  inputs delayed by STAGES clocks
// -----------------------------------------------------------------------------
module sync_chain #(
    parameter int unsigned WIDTH  = 1,
    parameter int unsigned STAGES = 2
) (
    input  logic             clock,
    input  logic             reset,
    input  logic [WIDTH-1:0] d_i,
    output logic [WIDTH-1:0] q_o
);

    logic [WIDTH-1:0] stage_q [STAGES];

    always_ff @(posedge clock) begin
        if (reset) begin
            // NOTE: this small array is reset on purpose: a stale low left in
            // the chain would look like a real strobe right after reset.
            for (int i = 0; i < int'(STAGES); i++) begin
                stage_q[i] <= '1;
            end
        end else begin
            // NOTE: non-blocking assignments make every stage take the value
            // its neighbour had before the edge, so the chain shifts by one.
            stage_q[0] <= d_i;
            for (int i = 1; i < int'(STAGES); i++) begin
                stage_q[i] <= stage_q[i-1];
            end
        end
    end

    assign q_o = stage_q[STAGES-1];

endmodule

// File: rtl/bus_cycle_controller.sv
// -----------------------------------------------------------------------------
// bus_cycle_controller
//   CPU bus-cycle terminator. For every address-strobe cycle it picks the
//   lowest-index active region select and terminates the cycle with a
//   programmed wait-state count and port size, defers to external (VME)
//   termination, or raises BERR. A watchdog raises BERR on cycles that never
//   terminate. All outputs are registered.
//   Ports:
//     clock           in   1            system clock (undivided board clock)
//     reset           in   1            synchronous, active-high
//     cpu_as          in   1            address strobe, active-low
//     cpu_fc          in   3            function code
//     region_request  in   NUM_REGIONS  decoded selects, active-low, bit 0 wins
//     ext_dsack       in   2            external DSACK, active-low code
//     ext_berr        in   1            external bus error, active-low
//     cpu_dsack_out   out  2            DSACK request, active-low
//     cpu_berr_out    out  1            BERR request, active-low
//     cycle_active    out  1            FSM is outside IDLE
//     timeout_pulse   out  1            one-clock pulse when the watchdog fires
// -----------------------------------------------------------------------------
module bus_cycle_controller
    import bus_cycle_controller_pkg::*;
#(
    parameter int unsigned                NUM_REGIONS    = 4,
    parameter logic [4*NUM_REGIONS-1:0]   WAIT_STATES    = '0,
    parameter logic [2*NUM_REGIONS-1:0]   PORT_SIZE      = '0,
    parameter logic [NUM_REGIONS-1:0]     EXT_MASK       = '0,
    parameter int unsigned                TIMEOUT_CYCLES = 256,
    parameter int unsigned                SYNC_STAGES    = 2
) (
    input  logic                   clock,
    input  logic                   reset,
    input  logic                   cpu_as,
    input  logic [2:0]             cpu_fc,
    input  logic [NUM_REGIONS-1:0] region_request,
    input  logic [1:0]             ext_dsack,
    input  logic                   ext_berr,
    output logic [1:0]             cpu_dsack_out,
    output logic                   cpu_berr_out,
    output logic                   cycle_active,
    output logic                   timeout_pulse
);

    localparam bit              WD_EN   = (TIMEOUT_CYCLES != 0);
    localparam int unsigned     TW      = WD_EN ? $clog2(TIMEOUT_CYCLES + 1) : 1;
    localparam logic [TW-1:0]   TC_LAST = WD_EN ? TW'(TIMEOUT_CYCLES - 1) : '0;
    localparam logic [TW-1:0]   TC_MAX  = TW'(TIMEOUT_CYCLES);

    // ---------------------------------------------------------------- inputs
    logic [3:0] sync_q;
    logic       as_s;
    logic [1:0] ext_dsack_s;
    logic       ext_berr_s;

    sync_chain #(
        .WIDTH  (4),
        .STAGES (SYNC_STAGES)
    ) u_sync (
        .clock (clock),
        .reset (reset),
        .d_i   ({cpu_as, ext_dsack, ext_berr}),
        .q_o   (sync_q)
    );

    assign {as_s, ext_dsack_s, ext_berr_s} = sync_q;

    // A cycle already running when reset was applied must not be acked. arm_q
    // remembers that AS was low at reset; each raw AS sample belonging to that
    // old cycle is tagged and the tag travels alongside as_s, so IDLE can tell
    // a stale strobe from a new one however the timing falls.
    logic                   arm_q;
    logic [SYNC_STAGES-1:0] stale_q;
    logic                   stale_s;

    always_ff @(posedge clock) begin
        if (reset) begin
            arm_q   <= (cpu_as == ACTIVE);
            stale_q <= '0;
        end else begin
            if (cpu_as == INACTIVE) begin
                arm_q <= 1'b0;
            end
            stale_q[0] <= arm_q & (cpu_as == ACTIVE);
            for (int i = 1; i < int'(SYNC_STAGES); i++) begin
                stale_q[i] <= stale_q[i-1];
            end
        end
    end

    assign stale_s = stale_q[SYNC_STAGES-1];

    // ------------------------------------------------------ region selection
    logic       hit;
    logic       hit_ext;
    logic [3:0] hit_wait;
    logic [1:0] hit_port;

    // Walk from the highest index down so the lowest active index is last.
    always_comb begin
        hit      = 1'b0;
        hit_ext  = 1'b0;
        hit_wait = '0;
        hit_port = DSACK_NONE;
        for (int i = int'(NUM_REGIONS) - 1; i >= 0; i--) begin
            if (region_request[i] == ACTIVE) begin
                hit      = 1'b1;
                hit_ext  = EXT_MASK[i];
                hit_wait = WAIT_STATES[4*i +: 4];
                hit_port = PORT_SIZE[2*i +: 2];
            end
        end
    end

    // ------------------------------------------------------------------- FSM
    state_e        state_q,  state_d;
    mode_e         mode_q,   mode_d;
    logic [1:0]    port_q,   port_d;
    logic [3:0]    wcnt_q,   wcnt_d;
    logic [TW-1:0] tcnt_q,   tcnt_d;
    logic [1:0]    dsack_q,  dsack_d;
    logic          berr_q,   berr_d;
    logic          active_q, active_d;
    logic          pulse_q,  pulse_d;
    logic          wd_hit;

    assign wd_hit = WD_EN && (tcnt_q >= TC_LAST);

    always_comb begin
        // NOTE: every variable gets a default before the case so no path
        // leaves it unassigned, which would otherwise infer a latch.
        state_d = state_q;
        mode_d  = mode_q;
        port_d  = port_q;
        wcnt_d  = wcnt_q;
        tcnt_d  = tcnt_q;
        dsack_d = dsack_q;
        berr_d  = berr_q;
        pulse_d = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                tcnt_d  = '0;
                dsack_d = DSACK_NONE;
                berr_d  = INACTIVE;
                if (as_s == ACTIVE) begin
                    if (stale_s) begin
                        state_d = ST_DRAIN;
                    end else begin
                        // tcnt counts clocks since the strobe was seen, so the
                        // watchdog fires TIMEOUT_CYCLES clocks after as_s fell.
                        tcnt_d = TW'(1);
                        if (!hit) begin
                            if (cpu_fc == FC_CPU_SPACE) begin
                                mode_d  = MODE_NONE;
                                state_d = ST_WAIT;
                            end else begin
                                state_d = ST_BERR;
                                berr_d  = ACTIVE;
                            end
                        end else if (hit_ext) begin
                            mode_d  = MODE_EXT;
                            state_d = ST_WAIT;
                        end else begin
                            mode_d = MODE_LOCAL;
                            port_d = hit_port;
                            wcnt_d = hit_wait;
                            if (hit_wait == 4'd0) begin
                                state_d = ST_ACK;
                                dsack_d = hit_port;
                            end else begin
                                state_d = ST_WAIT;
                            end
                        end
                    end
                end
            end

            ST_WAIT: begin
                if (tcnt_q < TC_MAX) begin
                    tcnt_d = tcnt_q + 1'b1;
                end
                if (mode_q == MODE_LOCAL && wcnt_q != 4'd0) begin
                    wcnt_d = wcnt_q - 4'd1;
                end
                // Priority: abort, then any termination, then the watchdog.
                if (as_s == INACTIVE) begin
                    state_d = ST_IDLE;
                end else if (mode_q == MODE_EXT && ext_berr_s == ACTIVE) begin
                    state_d = ST_BERR;
                    berr_d  = ACTIVE;
                end else if (mode_q == MODE_EXT && ext_dsack_s != DSACK_NONE) begin
                    state_d = ST_ACK;
                    dsack_d = ext_dsack_s;
                end else if (mode_q == MODE_LOCAL && wcnt_q <= 4'd1) begin
                    state_d = ST_ACK;
                    dsack_d = port_q;
                end else if (wd_hit) begin
                    state_d = ST_BERR;
                    berr_d  = ACTIVE;
                    pulse_d = 1'b1;
                end
            end

            ST_ACK: begin
                if (as_s == INACTIVE) begin
                    state_d = ST_IDLE;
                    dsack_d = DSACK_NONE;
                end
            end

            ST_BERR: begin
                if (as_s == INACTIVE) begin
                    state_d = ST_IDLE;
                    berr_d  = INACTIVE;
                end
            end

            ST_DRAIN: begin
                if (as_s == INACTIVE) begin
                    state_d = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
                dsack_d = DSACK_NONE;
                berr_d  = INACTIVE;
            end
        endcase

        active_d = (state_d != ST_IDLE);
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            mode_q   <= MODE_LOCAL;
            port_q   <= DSACK_32;
            wcnt_q   <= '0;
            tcnt_q   <= '0;
            dsack_q  <= DSACK_NONE;
            berr_q   <= INACTIVE;
            active_q <= 1'b0;
            pulse_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            mode_q   <= mode_d;
            port_q   <= port_d;
            wcnt_q   <= wcnt_d;
            tcnt_q   <= tcnt_d;
            dsack_q  <= dsack_d;
            berr_q   <= berr_d;
            active_q <= active_d;
            pulse_q  <= pulse_d;
        end
    end

    assign cpu_dsack_out = dsack_q;
    assign cpu_berr_out  = berr_q;
    assign cycle_active  = active_q;
    assign timeout_pulse = pulse_q;

endmodule

// File: tb/tb_bus_cycle_controller.sv
// -----------------------------------------------------------------------------
// tb_bus_cycle_controller
//   Self-checking bench. Each bus cycle is summarised as: clocks from AS low
//   to termination, the termination driven, number of watchdog pulses, whether
//   the termination held steady until AS rose, and clocks from AS high to
//   release. Expected summaries come from latency arithmetic on the
//   controller's rules (synchroniser delay, wait states, watchdog limit).
// -----------------------------------------------------------------------------
module tb_bus_cycle_controller;

    localparam int          S  = 2;    // SYNC_STAGES
    localparam int          T  = 16;   // TIMEOUT_CYCLES
    // Region 0: 0 waits 32b, region 1: 3 waits 8b, region 2: external,
    // region 3: 15 waits 16b (terminates on the same clock the watchdog would).
    localparam logic [15:0] WS = {4'd15, 4'd0, 4'd3, 4'd0};
    localparam logic [7:0]  PS = {2'b01, 2'b00, 2'b10, 2'b00};
    localparam logic [3:0]  EM = 4'b0100;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic       cpu_as = 1'b1;
    logic [2:0] cpu_fc = 3'b000;
    logic [3:0] region_request = 4'hF;
    logic [1:0] ext_dsack = 2'b11;
    logic       ext_berr = 1'b1;
    logic [1:0] cpu_dsack_out;
    logic       cpu_berr_out;
    logic       cycle_active;
    logic       timeout_pulse;

    int tests_run    = 0;
    int tests_failed = 0;

    typedef struct packed {
        logic [7:0] lat;      // clocks from AS low to first termination, 0 = none
        logic [1:0] dsack;
        logic       berr;
        logic [3:0] pulses;
        logic       held;
        logic [3:0] rel;      // clocks from AS high to fully idle outputs
    } res_t;

    bus_cycle_controller #(
        .NUM_REGIONS    (4),
        .WAIT_STATES    (WS),
        .PORT_SIZE      (PS),
        .EXT_MASK       (EM),
        .TIMEOUT_CYCLES (T),
        .SYNC_STAGES    (S)
    ) dut (
        .clock          (clock),
        .reset          (reset),
        .cpu_as         (cpu_as),
        .cpu_fc         (cpu_fc),
        .region_request (region_request),
        .ext_dsack      (ext_dsack),
        .ext_berr       (ext_berr),
        .cpu_dsack_out  (cpu_dsack_out),
        .cpu_berr_out   (cpu_berr_out),
        .cycle_active   (cycle_active),
        .timeout_pulse  (timeout_pulse)
    );

    always #5 clock = ~clock;

    initial begin
        #400000;
        $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
        $fatal(1, "bench time limit");
    end

    function automatic string fmt(input res_t r);
        return $sformatf("lat=%0d dsack=%b berr=%b pulses=%0d held=%b rel=%0d",
                         r.lat, r.dsack, r.berr, r.pulses, r.held, r.rel);
    endfunction

    // Reference: d = clocks after AS low at which ext pins are driven (<0: never).
    function automatic res_t model(input logic [3:0] req, input logic [2:0] fc,
                                   input int d, input logic [1:0] ecode, input logic eberr);
        res_t       r;
        logic [15:0] ws = WS;
        logic [7:0]  ps = PS;
        logic [3:0]  em = EM;
        int sel  = -1;
        int wd   = S + T;   // watchdog BERR latency
        int term = 0;       // termination latency, 0 = none coming
        logic [1:0] code = 2'b11;
        logic       be   = 1'b1;
        for (int i = 0; i < 4; i++) if (!req[i] && sel < 0) sel = i;
        if (sel < 0) begin
            if (fc != 3'b111) begin term = S + 1; be = 1'b0; end
        end else if (em[sel]) begin
            if (d >= 0 && (!eberr || ecode != 2'b11)) begin
                term = (d + S + 1 > S + 2) ? d + S + 1 : S + 2;
                if (!eberr) be = 1'b0; else code = ecode;
            end
        end else begin
            term = S + int'(ws[4*sel +: 4]) + 1;
            code = ps[2*sel +: 2];
        end
        r.held = 1'b1;
        r.rel  = 4'(S + 1);
        if (term != 0 && term <= wd) begin
            r.lat = 8'(term); r.dsack = code; r.berr = be; r.pulses = 4'd0;
        end else begin
            r.lat = 8'(wd); r.dsack = 2'b11; r.berr = 1'b0; r.pulses = 4'd1;
        end
        return r;
    endfunction

    task automatic drive_cycle(input logic [3:0] req, input logic [2:0] fc, input int d,
                               input logic [1:0] ecode, input logic eberr, output res_t obs);
        int         lat = 0;
        int         rel = 0;
        int         pulses = 0;
        logic       held = 1'b1;
        logic [1:0] ds = 2'b11;
        logic       be = 1'b1;
        @(negedge clock);
        region_request = req;
        cpu_fc         = fc;
        cpu_as         = 1'b0;
        if (d == 0) begin ext_dsack = ecode; ext_berr = eberr; end
        for (int k = 1; k <= S + T + 6 && lat == 0; k++) begin
            @(negedge clock);
            if (timeout_pulse) pulses++;
            if (cpu_dsack_out != 2'b11 || cpu_berr_out == 1'b0) begin
                lat = k; ds = cpu_dsack_out; be = cpu_berr_out;
            end else if (k == d) begin
                ext_dsack = ecode; ext_berr = eberr;
            end
        end
        if (lat != 0) begin
            repeat (3) begin
                @(negedge clock);
                if (timeout_pulse) pulses++;
                if (cpu_dsack_out !== ds || cpu_berr_out !== be || cycle_active !== 1'b1) held = 1'b0;
            end
        end
        cpu_as = 1'b1; ext_dsack = 2'b11; ext_berr = 1'b1; region_request = 4'hF;
        for (int r = 1; r <= 10 && rel == 0; r++) begin
            @(negedge clock);
            if (timeout_pulse) pulses++;
            if (!cycle_active && cpu_dsack_out == 2'b11 && cpu_berr_out == 1'b1) rel = r;
        end
        repeat (3) @(negedge clock);
        obs.lat = 8'(lat); obs.dsack = ds; obs.berr = be;
        obs.pulses = 4'(pulses); obs.held = held; obs.rel = 4'(rel);
    endtask

    task automatic test_reset();
        repeat (3) @(negedge clock);
        tests_run++;
        if (cpu_dsack_out !== 2'b11) begin tests_failed++; $display("FAIL reset_dsack: got %b, want 11", cpu_dsack_out); end
        tests_run++;
        if (cpu_berr_out !== 1'b1) begin tests_failed++; $display("FAIL reset_berr: got %b, want 1", cpu_berr_out); end
        tests_run++;
        if (cycle_active !== 1'b0) begin tests_failed++; $display("FAIL reset_active: got %b, want 0", cycle_active); end
        tests_run++;
        if (timeout_pulse !== 1'b0) begin tests_failed++; $display("FAIL reset_pulse: got %b, want 0", timeout_pulse); end
        reset = 1'b0;
        repeat (3) @(negedge clock);
    endtask

    task automatic test_local_wait();
        res_t obs, exp;
        drive_cycle(4'b1101, 3'b001, -1, 2'b11, 1'b1, obs);
        exp = model(4'b1101, 3'b001, -1, 2'b11, 1'b1);
        tests_run++;
        if (obs !== exp) begin tests_failed++; $display("FAIL local_wait: got %s, want %s", fmt(obs), fmt(exp)); end
    endtask

    task automatic test_priority();
        res_t obs, exp;
        drive_cycle(4'b1100, 3'b010, -1, 2'b11, 1'b1, obs);
        exp = model(4'b1100, 3'b010, -1, 2'b11, 1'b1);
        tests_run++;
        if (obs !== exp) begin tests_failed++; $display("FAIL priority: got %s, want %s", fmt(obs), fmt(exp)); end
    endtask

    task automatic test_external();
        res_t obs, exp;
        drive_cycle(4'b1011, 3'b001, 10, 2'b01, 1'b1, obs);
        exp = model(4'b1011, 3'b001, 10, 2'b01, 1'b1);
        tests_run++;
        if (obs !== exp) begin tests_failed++; $display("FAIL ext_dsack: got %s, want %s", fmt(obs), fmt(exp)); end
        drive_cycle(4'b1011, 3'b001, 10, 2'b01, 1'b0, obs);
        exp = model(4'b1011, 3'b001, 10, 2'b01, 1'b0);
        tests_run++;
        if (obs !== exp) begin tests_failed++; $display("FAIL ext_berr_wins: got %s, want %s", fmt(obs), fmt(exp)); end
    endtask

    task automatic test_timeout();
        res_t obs, exp;
        drive_cycle(4'b1011, 3'b001, -1, 2'b11, 1'b1, obs);
        exp = model(4'b1011, 3'b001, -1, 2'b11, 1'b1);
        tests_run++;
        if (obs !== exp) begin tests_failed++; $display("FAIL ext_timeout: got %s, want %s", fmt(obs), fmt(exp)); end
        // Last wait state lands on the watchdog's clock: termination must win.
        drive_cycle(4'b0111, 3'b001, -1, 2'b11, 1'b1, obs);
        exp = model(4'b0111, 3'b001, -1, 2'b11, 1'b1);
        tests_run++;
        if (obs !== exp) begin tests_failed++; $display("FAIL wait_vs_watchdog: got %s, want %s", fmt(obs), fmt(exp)); end
    endtask

    task automatic test_no_region();
        res_t obs, exp;
        drive_cycle(4'b1111, 3'b101, -1, 2'b11, 1'b1, obs);
        exp = model(4'b1111, 3'b101, -1, 2'b11, 1'b1);
        tests_run++;
        if (obs !== exp) begin tests_failed++; $display("FAIL no_region_fc5: got %s, want %s", fmt(obs), fmt(exp)); end
        drive_cycle(4'b1111, 3'b111, -1, 2'b11, 1'b1, obs);
        exp = model(4'b1111, 3'b111, -1, 2'b11, 1'b1);
        tests_run++;
        if (obs !== exp) begin tests_failed++; $display("FAIL no_region_fc7: got %s, want %s", fmt(obs), fmt(exp)); end
    endtask

    task automatic test_abort();
        int bad = 0;
        res_t obs, exp;
        @(negedge clock);
        region_request = 4'b0111; cpu_as = 1'b0;
        repeat (6) @(negedge clock);
        cpu_as = 1'b1; region_request = 4'hF;
        repeat (24) begin
            @(negedge clock);
            if (cpu_dsack_out != 2'b11 || cpu_berr_out != 1'b1 || timeout_pulse) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL abort_no_term: got %0d terminated clocks, want 0", bad); end
        drive_cycle(4'b1110, 3'b001, -1, 2'b11, 1'b1, obs);
        exp = model(4'b1110, 3'b001, -1, 2'b11, 1'b1);
        tests_run++;
        if (obs !== exp) begin tests_failed++; $display("FAIL after_abort: got %s, want %s", fmt(obs), fmt(exp)); end
    endtask

    task automatic test_reset_mid_wait();
        int bad = 0;
        res_t obs, exp;
        @(negedge clock);
        region_request = 4'b0111; cpu_as = 1'b0;
        repeat (6) @(negedge clock);
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        tests_run++;
        if (cpu_dsack_out !== 2'b11 || cpu_berr_out !== 1'b1 || cycle_active !== 1'b0 || timeout_pulse !== 1'b0) begin
            tests_failed++;
            $display("FAIL mid_reset_outputs: got dsack=%b berr=%b act=%b pulse=%b, want 11 1 0 0",
                     cpu_dsack_out, cpu_berr_out, cycle_active, timeout_pulse);
        end
        repeat (S + T + 8) begin
            @(negedge clock);
            if (cpu_dsack_out != 2'b11 || cpu_berr_out != 1'b1 || timeout_pulse) bad++;
        end
        tests_run++;
        if (bad != 0) begin tests_failed++; $display("FAIL mid_reset_drain: got %0d terminated clocks, want 0", bad); end
        cpu_as = 1'b1; region_request = 4'hF;
        repeat (S + 3) @(negedge clock);
        drive_cycle(4'b1101, 3'b001, -1, 2'b11, 1'b1, obs);
        exp = model(4'b1101, 3'b001, -1, 2'b11, 1'b1);
        tests_run++;
        if (obs !== exp) begin tests_failed++; $display("FAIL after_reset: got %s, want %s", fmt(obs), fmt(exp)); end
    endtask

    task automatic test_random();
        logic [1:0] code_tab [3] = '{2'b00, 2'b01, 2'b10};
        res_t obs, exp;
        for (int n = 0; n < 30; n++) begin
            logic [3:0] req   = 4'($urandom_range(0, 15));
            logic [2:0] fc    = 3'($urandom_range(0, 7));
            int         d     = int'($urandom_range(0, 20));
            int         kind  = int'($urandom_range(0, 5));
            logic [1:0] ecode = 2'b11;
            logic       eberr = 1'b1;
            if (kind < 3) ecode = code_tab[kind];
            else if (kind == 4) ecode = code_tab[$urandom_range(0, 2)];
            if (kind == 3 || kind == 4) eberr = 1'b0;
            drive_cycle(req, fc, d, ecode, eberr, obs);
            exp = model(req, fc, d, ecode, eberr);
            tests_run++;
            if (obs !== exp) begin
                tests_failed++;
                $display("FAIL random[%0d] req=%b fc=%b d=%0d ext=%b/%b: got %s, want %s",
                         n, req, fc, d, ecode, eberr, fmt(obs), fmt(exp));
            end
        end
    endtask

    initial begin
        test_reset();
        test_local_wait();
        test_priority();
        test_external();
        test_timeout();
        test_no_region();
        test_abort();
        test_reset_mid_wait();
        test_random();
        $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
        $finish;
    end

endmodule
